// File: rtl/c4_draw_scheduler.sv
// Connect Four tile-redraw scheduler: arbitrates a move FIFO and a latest-wins
// cursor slot onto a single LCD tile-draw engine, with inter-draw gap and watchdog.
module c4_draw_scheduler #(
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 2,
  parameter int TIMEOUT   = 4096,
  parameter int GAP       = 2
) (
  input  logic                       LCD_CLK,
  input  logic                       RESETN,
  input  logic                       MV_VALID,
  output logic                       MV_READY,
  input  logic [5:0]                 MV_POS,
  input  logic [1:0]                 MV_IMAGE,
  input  logic                       CUR_VALID,
  input  logic [5:0]                 CUR_POS,
  input  logic [1:0]                 CUR_IMAGE,
  output logic                       DRV_START,
  output logic [5:0]                 DRV_POS,
  output logic [1:0]                 DRV_IMAGE,
  input  logic                       DRV_DONE,
  input  logic                       ERR_CLR,
  output logic                       BUSY,
  output logic [$clog2(DEPTH+1)-1:0] FIFO_LEVEL,
  output logic                       TIMEOUT_ERR
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    head_word;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          cur_pend_q, cur_pend_d;
  logic [5:0]    cur_pos_q, cur_pos_d;
  logic [1:0]    cur_img_q, cur_img_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          err_q, err_d;
  logic [5:0]    pos_q, pos_d;
  logic [1:0]    img_q, img_d;
  logic          push, fifo_empty, grant_mv, grant_cur, wd_expire;

  assign fifo_empty = (level_q == '0);
  assign MV_READY   = (level_q != LW'(DEPTH));
  assign push       = MV_VALID & MV_READY;
  assign head_word  = mem_q[rd_q];
  // DONE wins over a watchdog expiring in the same cycle
  assign wd_expire  = (state_q == S_BUSY) && !DRV_DONE && (wdog_q == WW'(TIMEOUT - 1));

  always_comb begin
    grant_mv  = 1'b0;
    grant_cur = 1'b0;
    if (state_q == S_IDLE) begin
      if (!fifo_empty && (!cur_pend_q || (burst_q < BW'(MAX_BURST)))) grant_mv = 1'b1;
      else if (cur_pend_q) grant_cur = 1'b1;
    end
  end

  always_comb begin
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = grant_mv ? rd_q + AW'(1) : rd_q;
    level_d = level_q;
    case ({push, grant_mv})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // a coincident write survives the cursor grant, which takes the old value
    cur_pend_d = CUR_VALID ? 1'b1 : (grant_cur ? 1'b0 : cur_pend_q);
    cur_pos_d  = CUR_VALID ? CUR_POS : cur_pos_q;
    cur_img_d  = CUR_VALID ? CUR_IMAGE : cur_img_q;
  end

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    gap_d   = gap_q;
    pos_d   = pos_q;
    img_d   = img_q;
    burst_d = burst_q;
    err_d   = ERR_CLR ? 1'b0 : err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_mv) begin
          pos_d   = head_word[7:2];
          img_d   = head_word[1:0];
          state_d = S_ISSUE;
          if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + BW'(1);
        end else if (grant_cur) begin
          pos_d   = cur_pos_q;
          img_d   = cur_img_q;
          burst_d = '0;
          state_d = S_ISSUE;
        end
        if (fifo_empty) burst_d = '0;
      end
      S_ISSUE: begin
        state_d = S_BUSY;
        wdog_d  = '0;
      end
      S_BUSY: begin
        if (DRV_DONE || wd_expire) begin
          state_d = S_GAP;
          gap_d   = '0;
          if (wd_expire) err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      default: begin
        if (gap_q == GW'(GAP - 1)) state_d = S_IDLE;
        else gap_d = gap_q + GW'(1);
      end
    endcase
  end

  // FIFO storage carries no reset; occupancy is governed by the pointers
  always_ff @(posedge LCD_CLK) begin
    if (push) mem_q[wr_q] <= {MV_POS, MV_IMAGE};
  end

  always_ff @(posedge LCD_CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= S_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      cur_pend_q <= 1'b0;
      cur_pos_q  <= '0;
      cur_img_q  <= '0;
      burst_q    <= '0;
      wdog_q     <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      pos_q      <= '0;
      img_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      cur_pend_q <= cur_pend_d;
      cur_pos_q  <= cur_pos_d;
      cur_img_q  <= cur_img_d;
      burst_q    <= burst_d;
      wdog_q     <= wdog_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      pos_q      <= pos_d;
      img_q      <= img_d;
    end
  end

  assign DRV_START   = (state_q == S_ISSUE);
  assign DRV_POS     = pos_q;
  assign DRV_IMAGE   = img_q;
  assign BUSY        = (state_q != S_IDLE);
  assign FIFO_LEVEL  = level_q;
  assign TIMEOUT_ERR = err_q;
endmodule

// File: tb/tb_c4_draw_scheduler.sv
// Bench for c4_draw_scheduler: directed scenarios plus a randomized run against
// a transaction-level model of the move queue, cursor slot and draw timing.
module tb_c4_draw_scheduler;
  localparam int DEPTH = 4, MAX_BURST = 2, TIMEOUT = 16, GAP = 2;

  logic       LCD_CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       MV_VALID = 1'b0, MV_READY;
  logic [5:0] MV_POS = '0;
  logic [1:0] MV_IMAGE = '0;
  logic       CUR_VALID = 1'b0;
  logic [5:0] CUR_POS = '0;
  logic [1:0] CUR_IMAGE = '0;
  logic       DRV_START;
  logic [5:0] DRV_POS;
  logic [1:0] DRV_IMAGE;
  logic       DRV_DONE = 1'b0, ERR_CLR = 1'b0;
  logic       BUSY, TIMEOUT_ERR;
  logic [2:0] FIFO_LEVEL;

  int total = 0, bad = 0;
  int cyc = 0;
  logic [7:0] got[$];

  c4_draw_scheduler #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .LCD_CLK(LCD_CLK), .RESETN(RESETN), .MV_VALID(MV_VALID), .MV_READY(MV_READY),
    .MV_POS(MV_POS), .MV_IMAGE(MV_IMAGE), .CUR_VALID(CUR_VALID), .CUR_POS(CUR_POS),
    .CUR_IMAGE(CUR_IMAGE), .DRV_START(DRV_START), .DRV_POS(DRV_POS), .DRV_IMAGE(DRV_IMAGE),
    .DRV_DONE(DRV_DONE), .ERR_CLR(ERR_CLR), .BUSY(BUSY), .FIFO_LEVEL(FIFO_LEVEL),
    .TIMEOUT_ERR(TIMEOUT_ERR));

  always #5 LCD_CLK = ~LCD_CLK;
  always @(posedge LCD_CLK) cyc <= cyc + 1;

  task automatic tick();
    @(negedge LCD_CLK);
  endtask

  task automatic do_reset();
    MV_VALID = 0; CUR_VALID = 0; DRV_DONE = 0; ERR_CLR = 0;
    RESETN = 0;
    repeat (2) tick();
    RESETN = 1;
    tick();
  endtask

  task automatic wait_start(input int maxc, output bit ok);
    int n;
    n = 0;
    ok = 0;
    while (!ok && n < maxc) begin
      if (DRV_START === 1'b1) ok = 1;
      else begin tick(); n++; end
    end
  endtask

  // Acts as the draw engine: answers each DRV_START with DONE after lat cycles
  task automatic drain(input int lat, input int since0);
    int idle_run, n, since;
    idle_run = 0; n = 0; since = since0;
    got.delete();
    while (idle_run < 4 && n < 400) begin
      DRV_DONE = 0;
      if (DRV_START === 1'b1) begin
        got.push_back({DRV_POS, DRV_IMAGE});
        since = 0;
      end else if (since >= 0) begin
        since++;
        if (since == lat) begin DRV_DONE = 1; since = -1; end
      end
      idle_run = (BUSY === 1'b1) ? 0 : idle_run + 1;
      n++;
      tick();
    end
    DRV_DONE = 0;
    total++;
    if (n >= 400) begin bad++; $display("FAIL drain_bound: cycles=%0d required<400", n); end
  endtask

  task automatic test_reset();
    total++;
    if ({DRV_START, DRV_POS, DRV_IMAGE, BUSY, FIFO_LEVEL, TIMEOUT_ERR, MV_READY} !== 15'd1) begin
      bad++;
      $display("FAIL reset_outputs: got=%b required=%b",
               {DRV_START, DRV_POS, DRV_IMAGE, BUSY, FIFO_LEVEL, TIMEOUT_ERR, MV_READY}, 15'd1);
    end
  endtask

  task automatic test_single_move();
    MV_VALID = 1; MV_POS = 6'o23; MV_IMAGE = 2'd1;
    tick();
    MV_VALID = 0;
    total++;
    if (FIFO_LEVEL !== 3'd1 || BUSY !== 1'b0) begin
      bad++; $display("FAIL single_grant_cycle: level=%0d busy=%b required 1/0", FIFO_LEVEL, BUSY);
    end
    tick();
    total++;
    if ({DRV_START, DRV_POS, DRV_IMAGE} !== {1'b1, 6'o23, 2'd1}) begin
      bad++; $display("FAIL single_start: start=%b pos=%o img=%0d required 1/23/1", DRV_START, DRV_POS, DRV_IMAGE);
    end
    tick();
    total++;
    if (DRV_START !== 1'b0 || BUSY !== 1'b1 || FIFO_LEVEL !== 3'd0) begin
      bad++; $display("FAIL single_busy: start=%b busy=%b level=%0d required 0/1/0", DRV_START, BUSY, FIFO_LEVEL);
    end
    repeat (9) tick();
    DRV_DONE = 1;
    tick();
    DRV_DONE = 0;
    tick();
    total++;
    if (BUSY !== 1'b1) begin bad++; $display("FAIL single_gap: busy=%b required 1", BUSY); end
    tick();
    total++;
    if (BUSY !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%b required 0", BUSY); end
  endtask

  task automatic test_fifo_full();
    int accepted, d, n;
    MV_VALID = 1; MV_POS = 6'o70; MV_IMAGE = 2'd2;
    tick();
    MV_VALID = 0;
    repeat (2) tick();
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      MV_VALID = 1; MV_POS = 6'(accepted + 1); MV_IMAGE = 2'd1;
      if (MV_READY === 1'b1) accepted++;
      tick();
    end
    MV_POS = 6'(accepted + 1);
    total++;
    if (accepted != 4 || FIFO_LEVEL !== 3'd4 || MV_READY !== 1'b0) begin
      bad++; $display("FAIL fifo_full: accepted=%0d level=%0d ready=%b required 4/4/0", accepted, FIFO_LEVEL, MV_READY);
    end
    DRV_DONE = 1;
    d = cyc;
    tick();
    DRV_DONE = 0;
    n = 0;
    while (MV_READY !== 1'b1 && n < 30) begin tick(); n++; end
    total++;
    if (cyc - d != GAP + 2) begin
      bad++; $display("FAIL fifo_refill: accept_delay=%0d required=%0d", cyc - d, GAP + 2);
    end
    tick();
    MV_VALID = 0;
    drain(3, 1);
    total++;
    if (got.size() != 4) begin
      bad++; $display("FAIL fifo_order_count: got=%0d required=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got[i] !== {6'(i + 2), 2'd1}) begin
          bad++; $display("FAIL fifo_order[%0d]: got=%h required=%h", i, got[i], {6'(i + 2), 2'd1});
        end
      end
    end
  endtask

  task automatic test_burst_order();
    logic [7:0] exp[5];
    exp[0] = {6'd10, 2'd1}; exp[1] = {6'd11, 2'd1}; exp[2] = {6'o55, 2'd3};
    exp[3] = {6'd12, 2'd1}; exp[4] = {6'd13, 2'd1};
    CUR_VALID = 1; CUR_POS = 6'o77; CUR_IMAGE = 2'd3;
    tick();
    CUR_VALID = 0;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      MV_VALID = 1; MV_POS = 6'(10 + i); MV_IMAGE = 2'd1;
      tick();
    end
    MV_VALID = 0;
    CUR_VALID = 1; CUR_POS = 6'o55; CUR_IMAGE = 2'd3;
    tick();
    CUR_VALID = 0;
    DRV_DONE = 1;
    tick();
    DRV_DONE = 0;
    drain(2, -1);
    total++;
    if (got.size() != 5) begin
      bad++; $display("FAIL burst_count: got=%0d required=5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++; $display("FAIL burst_order[%0d]: got=%h required=%h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_cursor_latest();
    MV_VALID = 1; MV_POS = 6'o12; MV_IMAGE = 2'd2;
    tick();
    MV_VALID = 0;
    repeat (2) tick();
    CUR_VALID = 1; CUR_POS = 6'd1; CUR_IMAGE = 2'd3;
    tick();
    CUR_POS = 6'd9;
    tick();
    CUR_VALID = 0;
    tick();
    DRV_DONE = 1;
    tick();
    DRV_DONE = 0;
    drain(2, -1);
    total++;
    if (got.size() != 1 || got[0] !== {6'd9, 2'd3}) begin
      bad++; $display("FAIL cursor_latest: draws=%0d first=%h required 1/%h", got.size(),
                      (got.size() > 0) ? got[0] : 8'h00, {6'd9, 2'd3});
    end
  endtask

  task automatic test_timeout();
    bit ok;
    MV_VALID = 1; MV_POS = 6'o31; MV_IMAGE = 2'd2;
    tick();
    MV_VALID = 0;
    wait_start(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL timeout_start: start seen=%b required 1", ok); end
    repeat (TIMEOUT) tick();
    total++;
    if (TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL timeout_early: err=%b required 0", TIMEOUT_ERR); end
    tick();
    total++;
    if (TIMEOUT_ERR !== 1'b1) begin bad++; $display("FAIL timeout_set: err=%b required 1", TIMEOUT_ERR); end
    MV_VALID = 1; MV_POS = 6'o41; MV_IMAGE = 2'd1;
    tick();
    MV_VALID = 0;
    wait_start(20, ok);
    total++;
    if (!ok || DRV_POS !== 6'o41) begin
      bad++; $display("FAIL timeout_next: started=%b pos=%o required 1/41", ok, DRV_POS);
    end
    drain(2, -1);
    total++;
    if (TIMEOUT_ERR !== 1'b1) begin bad++; $display("FAIL timeout_sticky: err=%b required 1", TIMEOUT_ERR); end
    ERR_CLR = 1;
    tick();
    ERR_CLR = 0;
    total++;
    if (TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL timeout_clear: err=%b required 0", TIMEOUT_ERR); end
  endtask

  task automatic test_reset_mid_draw();
    int starts;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      MV_VALID = 1; MV_POS = 6'(20 + i); MV_IMAGE = 2'd2;
      tick();
    end
    MV_VALID = 0;
    total++;
    if (FIFO_LEVEL !== 3'd3 || BUSY !== 1'b1) begin
      bad++; $display("FAIL rst_precond: level=%0d busy=%b required 3/1", FIFO_LEVEL, BUSY);
    end
    CUR_VALID = 1; CUR_POS = 6'd5; CUR_IMAGE = 2'd3;
    tick();
    CUR_VALID = 0;
    RESETN = 0;
    #1;
    total++;
    if ({DRV_START, DRV_POS, DRV_IMAGE, BUSY, FIFO_LEVEL, TIMEOUT_ERR, MV_READY} !== 15'd1) begin
      bad++;
      $display("FAIL rst_mid_outputs: got=%b required=%b",
               {DRV_START, DRV_POS, DRV_IMAGE, BUSY, FIFO_LEVEL, TIMEOUT_ERR, MV_READY}, 15'd1);
    end
    tick();
    RESETN = 1;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (DRV_START === 1'b1 || BUSY === 1'b1) starts++;
    end
    total++;
    if (starts != 0) begin bad++; $display("FAIL rst_quiet: activity=%0d required 0", starts); end
    MV_VALID = 1; MV_POS = 6'o66; MV_IMAGE = 2'd1;
    tick();
    MV_VALID = 0;
    wait_start(10, ok);
    total++;
    if (!ok || {DRV_POS, DRV_IMAGE} !== {6'o66, 2'd1}) begin
      bad++; $display("FAIL rst_new_req: started=%b pos=%o img=%0d required 1/66/1", ok, DRV_POS, DRV_IMAGE);
    end
    drain(2, -1);
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] cv, exp_drv;
    bit cp, mv, cu, empty0, room, granted;
    int burst, arb_at, start_c, done_c;
    do_reset();
    cp = 0; cv = '0; exp_drv = '0; burst = 0; arb_at = 0; start_c = -1; done_c = -1;
    for (int c = 0; c < 800; c++) begin
      total++;
      if (DRV_START !== 1'(c == start_c)) begin
        bad++; $display("FAIL rnd_start c=%0d: got=%b required=%b", c, DRV_START, c == start_c);
      end
      if (c == start_c) begin
        total++;
        if ({DRV_POS, DRV_IMAGE} !== exp_drv) begin
          bad++; $display("FAIL rnd_draw c=%0d: got=%h required=%h", c, {DRV_POS, DRV_IMAGE}, exp_drv);
        end
      end
      total++;
      if (FIFO_LEVEL !== 3'(q.size()) || MV_READY !== 1'(q.size() < DEPTH)) begin
        bad++; $display("FAIL rnd_level c=%0d: level=%0d ready=%b required level=%0d", c, FIFO_LEVEL, MV_READY, q.size());
      end
      total++;
      if (BUSY !== 1'(c < arb_at) || TIMEOUT_ERR !== 1'b0) begin
        bad++; $display("FAIL rnd_busy c=%0d: busy=%b err=%b required busy=%b err=0", c, BUSY, TIMEOUT_ERR, c < arb_at);
      end
      mv = ($urandom_range(0, 99) < 45);
      cu = ($urandom_range(0, 99) < 10);
      MV_VALID = mv; MV_POS = 6'($urandom); MV_IMAGE = 2'($urandom);
      CUR_VALID = cu; CUR_POS = 6'($urandom); CUR_IMAGE = 2'($urandom);
      DRV_DONE = (c == done_c) || (!(c > start_c && c <= done_c) && $urandom_range(0, 9) == 0);
      empty0 = (q.size() == 0);
      room = (q.size() < DEPTH);
      granted = 0;
      if (c >= arb_at) begin
        if (!empty0 && (!cp || burst < MAX_BURST)) begin
          exp_drv = q.pop_front();
          if (burst < MAX_BURST) burst++;
          granted = 1;
        end else if (cp) begin
          exp_drv = cv; cp = 0; burst = 0; granted = 1;
        end
        if (empty0) burst = 0;
        if (granted) begin
          start_c = c + 1;
          done_c = start_c + $urandom_range(1, 10);
          arb_at = done_c + GAP + 1;
        end
      end
      if (mv && room) q.push_back({MV_POS, MV_IMAGE});
      if (cu) begin cp = 1; cv = {CUR_POS, CUR_IMAGE}; end
      tick();
    end
    MV_VALID = 0; CUR_VALID = 0; DRV_DONE = 0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_move();
    test_fifo_full();
    test_burst_order();
    test_cursor_latest();
    test_timeout();
    test_reset_mid_draw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
